mem_access_stage: RTL and testbench



---
 rtl/mem_access_stage_pkg.sv | 14 +
 rtl/mem_timeout_counter.sv | 29 ++
 rtl/mem_access_stage.sv | 136 +++++++++++++
 tb/tb_mem_access_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage.
package mem_access_stage_pkg;

    localparam int RD_MSB = 11;
    localparam int RD_LSB = 9;

    typedef logic [15:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        MEM  = 1'b1
    } state_e;

endpackage

// File: rtl/mem_timeout_counter.sv
// Cycle counter for an outstanding memory request; tc flags the last allowed wait cycle.
module mem_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: passes ALU results through, or runs one load/store on the
// data port with req/ack, then emits a single-cycle writeback packet.
//
// state | meaning
// IDLE  | ready for a packet; non-memory packets retire here in one cycle
// MEM   | request outstanding, waiting for mem_ack or timeout
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_isld,
    input  logic              in_isst,
    input  logic              in_iswb,
    input  logic [15:0]       in_aluresult,
    input  logic [15:0]       in_stdata,
    input  logic [15:0]       in_instr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic              wb_valid,
    output logic [2:0]        wb_rd,
    output logic [15:0]       wb_data,
    output logic [15:0]       wb_instr,
    output logic              mem_err
);

    state_e state_q, state_d;
    word_t  instr_q;
    logic   start_mem, pass_thru, ack_done, timeout;
    logic   tc;
    logic   unused_addr_bits;

    assign unused_addr_bits = ^in_aluresult[15:ADDR_W];
    assign in_ready = (state_q == IDLE);

    mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start_mem),
        .enable ((state_q == MEM) && !mem_ack),
        .tc     (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An ack in the timeout cycle takes priority, so the access completes normally.
    always_comb begin
        state_d   = state_q;
        start_mem = 1'b0;
        pass_thru = 1'b0;
        ack_done  = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_isld || in_isst) begin
                        start_mem = 1'b1;
                        state_d   = MEM;
                    end else begin
                        pass_thru = 1'b1;
                    end
                end
            end
            MEM: begin
                if (mem_ack) begin
                    ack_done = 1'b1;
                    state_d  = IDLE;
                end else if (tc) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            instr_q   <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            wb_instr  <= '0;
            mem_err   <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (pass_thru) begin
                wb_valid <= in_iswb;
                wb_data  <= in_aluresult;
                wb_rd    <= in_instr[RD_MSB:RD_LSB];
                wb_instr <= in_instr;
            end
            // Load wins when both ld and st are flagged, so mem_we alone marks a store.
            if (start_mem) begin
                mem_req   <= 1'b1;
                mem_we    <= in_isst & ~in_isld;
                mem_addr  <= in_aluresult[ADDR_W-1:0];
                mem_wdata <= in_stdata;
                instr_q   <= in_instr;
            end
            if (ack_done) begin
                mem_req  <= 1'b0;
                wb_instr <= instr_q;
                if (!mem_we) begin
                    wb_valid <= 1'b1;
                    wb_data  <= mem_rdata;
                    wb_rd    <= instr_q[RD_MSB:RD_LSB];
                end
            end
            if (timeout) begin
                mem_req <= 1'b0;
                mem_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_isld, in_isst, in_iswb;
    logic        in_ready;
    logic [15:0] in_aluresult, in_stdata, in_instr;
    logic        mem_req, mem_we, mem_ack;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        wb_valid, mem_err;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data, wb_instr;

    int checks = 0;
    int errors = 0;
    int cnt;

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(8), .TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_isld      (in_isld),
        .in_isst      (in_isst),
        .in_iswb      (in_iswb),
        .in_aluresult (in_aluresult),
        .in_stdata    (in_stdata),
        .in_instr     (in_instr),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_instr     (wb_instr),
        .mem_err      (mem_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic ld, input logic st, input logic wb,
                         input logic [15:0] alu, input logic [15:0] sd, input logic [15:0] ins);
        in_valid = v; in_isld = ld; in_isst = st; in_iswb = wb;
        in_aluresult = alu; in_stdata = sd; in_instr = ins;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        mem_ack = 1'b0;
        mem_rdata = 16'h0;
        rst_n = 1'b0;
        #12;
        check("rst_mem_req", mem_req, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_mem_err", mem_err, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_wb_data", wb_data, 0);
        check("rst_mem_addr", mem_addr, 0);
        tick();
        rst_n = 1'b1;

        // back-to-back non-memory packets
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 1, 16'h0042 + 16'(i), 16'h0, 16'h0A00);
            tick();
            check("alu_wb_valid", wb_valid, 1);
            check("alu_wb_rd", wb_rd, 5);
            check("alu_wb_data", wb_data, 32'h0042 + i);
            check("alu_in_ready", in_ready, 1);
        end
        drive(1, 0, 0, 0, 16'h0099, 16'h0, 16'h0C00);
        tick();
        check("nowb_valid", wb_valid, 0);
        check("nowb_instr", wb_instr, 16'h0C00);
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        tick();
        check("idle_wb_valid", wb_valid, 0);

        // load, ack after 2 wait cycles
        drive(1, 1, 0, 0, 16'h0110, 16'h5555, 16'h0600);
        tick();
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        check("ld_req", mem_req, 1);
        check("ld_addr", mem_addr, 8'h10);
        check("ld_we", mem_we, 0);
        check("ld_ready", in_ready, 0);
        check("ld_wb_valid0", wb_valid, 0);
        tick();
        check("ld_ready_w1", in_ready, 0);
        check("ld_req_w1", mem_req, 1);
        tick();
        check("ld_ready_w2", in_ready, 0);
        check("ld_addr_w2", mem_addr, 8'h10);
        mem_ack = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        check("ld_wb_valid", wb_valid, 1);
        check("ld_wb_rd", wb_rd, 3);
        check("ld_wb_data", wb_data, 16'hBEEF);
        check("ld_wb_instr", wb_instr, 16'h0600);
        check("ld_req_drop", mem_req, 0);
        check("ld_ready_after", in_ready, 1);
        tick();
        check("ld_pulse", wb_valid, 0);

        // ld+st together is a load
        drive(1, 1, 1, 0, 16'h00A5, 16'h7777, 16'h0200);
        tick();
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        check("ldst_we", mem_we, 0);
        check("ldst_addr", mem_addr, 8'hA5);
        mem_ack = 1'b1;
        mem_rdata = 16'h1111;
        tick();
        mem_ack = 1'b0;
        check("ldst_wb_valid", wb_valid, 1);
        check("ldst_wb_data", wb_data, 16'h1111);

        // store, ack in first MEM cycle
        drive(1, 0, 1, 0, 16'h0020, 16'h1234, 16'h0E00);
        tick();
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        check("st_we", mem_we, 1);
        check("st_wdata", mem_wdata, 16'h1234);
        check("st_addr", mem_addr, 8'h20);
        check("st_req", mem_req, 1);
        mem_ack = 1'b1;
        tick();
        check("st_wb_valid", wb_valid, 0);
        check("st_wb_instr", wb_instr, 16'h0E00);
        check("st_wb_data_kept", wb_data, 16'h1111);
        check("st_ready", in_ready, 1);
        check("st_req_drop", mem_req, 0);
        // ack while idle is ignored
        tick();
        mem_ack = 1'b0;
        check("idle_ack_valid", wb_valid, 0);
        check("idle_ack_req", mem_req, 0);

        // timeout: request held for exactly 16 cycles
        drive(1, 1, 0, 0, 16'h0033, 16'h0, 16'h0200);
        tick();
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        cnt = 0;
        while (mem_req && cnt < 40) begin
            cnt++;
            check("to_ready_low", in_ready, 0);
            tick();
        end
        check("to_req_cycles", cnt, 16);
        check("to_err", mem_err, 1);
        check("to_wb_valid", wb_valid, 0);
        check("to_ready", in_ready, 1);
        tick();
        check("to_err_sticky", mem_err, 1);
        drive(1, 0, 0, 1, 16'h7777, 16'h0, 16'h0E00);
        tick();
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        check("to_alu_valid", wb_valid, 1);
        check("to_alu_rd", wb_rd, 7);
        check("to_alu_data", wb_data, 16'h7777);
        check("to_err_kept", mem_err, 1);

        // ack in the timeout cycle wins
        do_reset();
        check("rst_clears_err", mem_err, 0);
        drive(1, 1, 0, 0, 16'h0044, 16'h0, 16'h0800);
        tick();
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < 15; i++) tick();
        check("tack_req", mem_req, 1);
        mem_ack = 1'b1;
        mem_rdata = 16'hCAFE;
        tick();
        mem_ack = 1'b0;
        check("tack_wb_valid", wb_valid, 1);
        check("tack_wb_data", wb_data, 16'hCAFE);
        check("tack_wb_rd", wb_rd, 4);
        check("tack_err", mem_err, 0);
        check("tack_req_drop", mem_req, 0);
        tick();
        check("tack_err_later", mem_err, 0);

        // reset in the middle of a load
        drive(1, 1, 0, 0, 16'h0055, 16'h0, 16'h0A00);
        tick();
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        tick();
        tick();
        check("rmid_req_before", mem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rmid_req_async", mem_req, 0);
        check("rmid_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 16'hDEAD;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_ack = 1'b0;
            if (wb_valid) cnt++;
        end
        check("rmid_no_wb", cnt, 0);
        check("rmid_ready_after", in_ready, 1);
        check("rmid_req_after", mem_req, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
